input_window_fetch_ctrl: RTL

//  Sequences the 16-bit input-feature-map on-chip read master for the conv layer.
//  On start, it walks a HxW tile at cfg_base and issues the 3x3 sliding-window addresses.

---
 rtl/input_window_fetch_ctrl_if.sv | 61 ++++++
 rtl/input_window_fetch_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_window_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// input_window_fetch_ctrl_if
// Bus bundle between the window-fetch controller and its two neighbours:
//   - the on-chip read master (rd_*)
//   - the PE-array pixel stream (pix_*)
//
// Handshake semantics:
//   Read side : rd_en/rd_addr are driven by the controller. While rd_en is
//               high, rd_addr is held stable. The read master answers with a
//               single-cycle rd_valid pulse; rd_data on that cycle belongs to
//               the current rd_addr. Only one read is outstanding at a time.
//   Pixel side: valid/ready. A word moves on any cycle where pix_valid and
//               pix_ready are both high. Once pix_valid is raised, pix_data,
//               pix_last_win and pix_last are held until that transfer.
//
// Modports:
//   master - the controller (drives rd_en, rd_addr, pix_data, pix_valid,
//            pix_last_win, pix_last; receives rd_data, rd_valid, pix_ready)
//   slave  - the environment (read master + PE array)
// ---------------------------------------------------------------------------
interface input_window_fetch_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) ();

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last_win;
  logic              pix_last;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    input  rd_valid,
    output pix_data,
    output pix_valid,
    output pix_last_win,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    output rd_valid,
    input  pix_data,
    input  pix_valid,
    input  pix_last_win,
    input  pix_last,
    output pix_ready
  );

endinterface

// File: rtl/input_window_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// input_window_fetch_ctrl
// Walks an HxW tile of 16-bit feature words starting at cfg_base and issues
// the 3x3 sliding-window read addresses to the on-chip read master. Windows
// are visited row-major (r,c); inside a window the order is kr then kc.
// Returned words pass through a small first-word-fall-through buffer and
// leave as a valid/ready stream tagged with window-last and tile-last.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 1-cycle pulse, cfg_* sampled on the same cycle
//   cfg_base              tile base address
//   cfg_width, cfg_height tile dimensions W, H (both must be >= 3)
//   busy                  high in ISSUE and DRAIN
//   done                  1-cycle pulse at end of tile
//   err                   1-cycle pulse with done when W<3 or H<3
//   dbg_state             current FSM state (IDLE=0, ISSUE=1, DRAIN=2, DONE=3)
//   bus                   read master + pixel stream (see interface file)
// ---------------------------------------------------------------------------
module input_window_fetch_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int DIM_W  = 8,
  parameter int FIFO_D = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         cfg_base,
  input  logic [DIM_W-1:0]          cfg_width,
  input  logic [DIM_W-1:0]          cfg_height,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                dbg_state,
  input_window_fetch_ctrl_if.master bus
);

  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] base_q,     base_d;
  logic [DIM_W-1:0]  w_q,        w_d;
  logic [DIM_W-1:0]  h_q,        h_d;
  logic [DIM_W-1:0]  r_q,        r_d;
  logic [DIM_W-1:0]  c_q,        c_d;
  logic [1:0]        kr_q,       kr_d;
  logic [1:0]        kc_q,       kc_d;
  logic              err_flag_q, err_flag_d;

  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              err_q,      err_d;
  logic              rd_en_q,    rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;

  // Return buffer: each entry is {tile_last, win_last, data}.
  logic [ENT_W-1:0]  fifo_mem_q [FIFO_D];
  logic [ENT_W-1:0]  fifo_mem_d [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic              cfg_ok;
  logic              rd_accept;
  logic              push;
  logic              pop;
  logic              fifo_nonempty;
  logic              win_last;
  logic              col_last;
  logic              row_last;
  logic              tile_last;
  logic [DIM_W:0]    row_n;
  logic [DIM_W:0]    col_n;
  logic [ADDR_W-1:0] row_a;
  logic [ADDR_W-1:0] col_a;
  logic [ADDR_W-1:0] w_a;
  logic [ADDR_W-1:0] addr_calc;
  logic [ENT_W-1:0]  head;

  assign cfg_ok        = (cfg_width >= DIM_W'(3)) && (cfg_height >= DIM_W'(3));
  assign fifo_nonempty = (count_q != '0);

  // A returned word only counts while a read is actually outstanding.
  assign rd_accept = (state_q == S_ISSUE) && rd_en_q && bus.rd_valid;
  assign push      = rd_accept;
  assign pop       = fifo_nonempty && bus.pix_ready;

  assign win_last  = (kr_q == 2'd2) && (kc_q == 2'd2);
  assign col_last  = (c_q == (w_q - DIM_W'(3)));
  assign row_last  = (r_q == (h_q - DIM_W'(3)));
  assign tile_last = win_last && col_last && row_last;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    w_d        = w_q;
    h_d        = h_q;
    r_d        = r_q;
    c_d        = c_q;
    kr_d       = kr_q;
    kc_d       = kc_q;
    err_flag_d = err_flag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_mem_d = fifo_mem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = cfg_base;
          w_d    = cfg_width;
          h_d    = cfg_height;
          r_d    = '0;
          c_d    = '0;
          kr_d   = '0;
          kc_d   = '0;
          if (cfg_ok) begin
            err_flag_d = 1'b0;
            state_d    = S_ISSUE;
          end else begin
            err_flag_d = 1'b1;
            state_d    = S_DONE;
          end
        end
      end

      S_ISSUE: begin
        if (rd_accept) begin
          // Odometer: kc fastest, then kr, then c, then r.
          if (kc_q != 2'd2) begin
            kc_d = kc_q + 2'd1;
          end else begin
            kc_d = '0;
            if (kr_q != 2'd2) begin
              kr_d = kr_q + 2'd1;
            end else begin
              kr_d = '0;
              if (!col_last) begin
                c_d = c_q + DIM_W'(1);
              end else begin
                c_d = '0;
                r_d = r_q + DIM_W'(1);
              end
            end
          end
          if (tile_last) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // Empty buffer means the tile-last word has already been taken.
        if (!fifo_nonempty) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (push) begin
      fifo_mem_d[wr_ptr_q] = {tile_last, win_last, bus.rd_data};
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};

    // Two free slots before asking: the outstanding read plus margin, so a
    // returning word can never find the buffer full. Since free space only
    // shrinks on a push (which also ends the read), rd_en never drops while
    // a read is still outstanding and rd_addr stays put.
    rd_en_d = (state_d == S_ISSUE) && (count_d <= CNT_W'(FIFO_D - 2));

    // base + (r+kr)*W + (c+kc), all taken mod 2^ADDR_W; wrap is intended.
    row_n     = {1'b0, r_d} + {{(DIM_W-1){1'b0}}, kr_d};
    col_n     = {1'b0, c_d} + {{(DIM_W-1){1'b0}}, kc_d};
    row_a     = ADDR_W'(row_n);
    col_a     = ADDR_W'(col_n);
    w_a       = ADDR_W'(w_d);
    addr_calc = base_d + (row_a * w_a) + col_a;
    rd_addr_d = (state_d == S_ISSUE) ? addr_calc : rd_addr_q;

    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_DONE) && err_flag_d;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      w_q        <= '0;
      h_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      err_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_D; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      w_q        <= w_d;
      h_q        <= h_d;
      r_q        <= r_d;
      c_q        <= c_d;
      kr_q       <= kr_d;
      kc_q       <= kc_d;
      err_flag_q <= err_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fifo_mem_q <= fifo_mem_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign head = fifo_mem_q[rd_ptr_q];

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  assign bus.rd_en        = rd_en_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.pix_valid    = fifo_nonempty;
  assign bus.pix_data     = head[DATA_W-1:0];
  assign bus.pix_last_win = fifo_nonempty && head[DATA_W];
  assign bus.pix_last     = fifo_nonempty && head[DATA_W+1];

endmodule
